// File: rtl/seq_lock_ctrl.sv
// Keypad code lock: collects SEQ_LEN single-key presses, compares them against
// a programmed code and toggles the lock state, with error hold and lockout.
module seq_lock_ctrl #(
  parameter int NKEYS          = 4,
  parameter int KEYW           = $clog2(NKEYS),
  parameter int SEQ_LEN        = 4,
  parameter int ENTRY_TIMEOUT  = 250_000_000,
  parameter int ERROR_HOLD     = 250_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1_500_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NKEYS-1:0]               key,
  input  logic [SEQ_LEN*KEYW-1:0]        code,
  output logic                           unlocked,
  output logic                           match,
  output logic                           error,
  output logic                           locked_out,
  output logic [NKEYS-1:0]               led,
  output logic [$clog2(SEQ_LEN+1)-1:0]   digit_cnt,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic [2:0]                     state
);
  localparam int DCW    = $clog2(SEQ_LEN+1);
  localparam int FCW    = $clog2(MAX_FAILS+1);
  localparam int TMAX_A = (ENTRY_TIMEOUT > ERROR_HOLD) ? ENTRY_TIMEOUT : ERROR_HOLD;
  localparam int TMAX   = (TMAX_A > LOCKOUT_CYCLES) ? TMAX_A : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ERROR   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  function automatic logic one_low(input logic [NKEYS-1:0] k);
    logic [NKEYS-1:0] inv;
    inv = ~k;
    return (inv != '0) && ((inv & (inv - NKEYS'(1))) == '0);
  endfunction

  // Only called with exactly one bit low, so OR-ing indices is exact.
  function automatic logic [KEYW-1:0] key_index(input logic [NKEYS-1:0] k);
    logic [KEYW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      idx = idx | (k[i] ? KEYW'(0) : KEYW'(i));
    end
    return idx;
  endfunction

  state_t                  state_r;
  logic [NKEYS-1:0]        key_r;
  logic [NKEYS-1:0]        key_prev_r;
  logic [SEQ_LEN*KEYW-1:0] digits_r;
  logic [DCW-1:0]          digit_cnt_r;
  logic [FCW-1:0]          fail_cnt_r;
  logic [TW-1:0]           timer_r;
  logic                    unlocked_r;
  logic                    match_r;
  logic                    error_r;
  logic                    locked_out_r;
  logic [NKEYS-1:0]        led_r;
  logic [NKEYS-1:0]        last_led_r;

  logic           press_s;
  logic           released_s;
  logic           to_check_s;
  logic           timeout_s;
  logic           go_fail_s;
  logic [TW-1:0]  timer_inc_s;
  logic [FCW-1:0] fail_next_s;

  assign press_s     = one_low(key_r) && (key_prev_r == '1);
  assign released_s  = (key_r == '1);
  assign timer_inc_s = (timer_r == '1) ? timer_r : timer_r + TW'(1);
  assign fail_next_s = fail_cnt_r + FCW'(1);
  assign to_check_s  = (state_r == ST_ENTRY) && (digit_cnt_r == DCW'(SEQ_LEN)) && released_s;
  // A press in the same cycle as the timeout wins over the timeout.
  assign timeout_s   = (state_r == ST_ENTRY) && !press_s && !to_check_s &&
                       (timer_inc_s == TW'(ENTRY_TIMEOUT));
  assign go_fail_s   = timeout_s || ((state_r == ST_CHECK) && (digits_r != code));

  // Lock controller state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      key_r        <= '1;
      key_prev_r   <= '1;
      digits_r     <= '0;
      digit_cnt_r  <= '0;
      fail_cnt_r   <= '0;
      timer_r      <= '0;
      unlocked_r   <= 1'b0;
      match_r      <= 1'b0;
      error_r      <= 1'b0;
      locked_out_r <= 1'b0;
      led_r        <= '0;
      last_led_r   <= '0;
    end else begin
      key_r      <= key;
      key_prev_r <= key_r;
      match_r    <= 1'b0;
      if (!enable) begin
        state_r      <= ST_IDLE;
        digit_cnt_r  <= '0;
        timer_r      <= '0;
        error_r      <= 1'b0;
        locked_out_r <= 1'b0;
        // Leave one failure short of lockout so an abort cannot dodge it.
        if (state_r == ST_LOCKOUT) begin
          fail_cnt_r <= FCW'(MAX_FAILS - 1);
        end else begin
          fail_cnt_r <= fail_cnt_r;
        end
      end else if (go_fail_s) begin
        fail_cnt_r  <= fail_next_s;
        digit_cnt_r <= '0;
        timer_r     <= '0;
        led_r       <= '1;
        if (fail_next_s == FCW'(MAX_FAILS)) begin
          state_r      <= ST_LOCKOUT;
          locked_out_r <= 1'b1;
        end else begin
          state_r <= ST_ERROR;
          error_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (press_s) begin
              digits_r[0 +: KEYW] <= key_index(key_r);
              digit_cnt_r         <= DCW'(1);
              led_r               <= ~key_r;
              last_led_r          <= ~key_r;
              timer_r             <= '0;
              state_r             <= ST_ENTRY;
            end
          end
          ST_ENTRY: begin
            if (press_s) begin
              timer_r <= '0;
              if (digit_cnt_r < DCW'(SEQ_LEN)) begin
                digits_r[int'(digit_cnt_r)*KEYW +: KEYW] <= key_index(key_r);
                digit_cnt_r <= digit_cnt_r + DCW'(1);
                led_r       <= ~key_r;
                last_led_r  <= ~key_r;
              end
            end else if (to_check_s) begin
              state_r <= ST_CHECK;
            end else begin
              timer_r <= timer_inc_s;
            end
          end
          ST_CHECK: begin
            unlocked_r  <= ~unlocked_r;
            match_r     <= 1'b1;
            fail_cnt_r  <= '0;
            digit_cnt_r <= '0;
            state_r     <= ST_IDLE;
          end
          ST_ERROR: begin
            if (timer_inc_s == TW'(ERROR_HOLD)) begin
              state_r <= ST_IDLE;
              error_r <= 1'b0;
              led_r   <= last_led_r;
              timer_r <= '0;
            end else begin
              timer_r <= timer_inc_s;
            end
          end
          ST_LOCKOUT: begin
            if (timer_inc_s == TW'(LOCKOUT_CYCLES)) begin
              state_r      <= ST_IDLE;
              locked_out_r <= 1'b0;
              fail_cnt_r   <= '0;
              led_r        <= last_led_r;
              timer_r      <= '0;
            end else begin
              timer_r <= timer_inc_s;
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            digit_cnt_r  <= '0;
            timer_r      <= '0;
            error_r      <= 1'b0;
            locked_out_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign unlocked   = unlocked_r;
  assign match      = match_r;
  assign error      = error_r;
  assign locked_out = locked_out_r;
  assign led        = led_r;
  assign digit_cnt  = digit_cnt_r;
  assign fail_cnt   = fail_cnt_r;
  assign state      = state_r;

endmodule

// File: doc/seq_lock_ctrl.md
# seq_lock_ctrl

Parametrised successor to the push-button lock FSM. It takes an N-button, active-low keypad and collects a code of configurable length. Each code is checked against a programmed value. A correct code toggles the lock state; wrong codes and timeouts count as failures, and repeated failures force a timed lockout. Entry and error timers are internal, so no separate timer block is needed. The block sits between the debounced key inputs and the display/LED drivers.

## Interface
- NKEYS, 4: number of push buttons (≥2).
- KEYW, $clog2(NKEYS): bits per stored digit.
- SEQ_LEN, 4: digits per code (≥1).
- ENTRY_TIMEOUT, 250_000_000: max idle cycles between digits during entry.
- ERROR_HOLD, 250_000_000: cycles the error indication is held.
- MAX_FAILS, 3: consecutive failures that trigger lockout (≥1).
- LOCKOUT_CYCLES, 1_500_000_000: lockout duration in cycles.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; low aborts entry.
- key  in  NKEYS  push buttons, active-low, already synchronised and debounced; bit i = key i.
- code  in  SEQ_LEN*KEYW  expected code; digit j at bits [j*KEYW +: KEYW], digit 0 entered first.
- unlocked  out  1  lock state, toggled by each correct code.
- match  out  1  one-cycle pulse on a correct code.
- error  out  1  high throughout ERROR.
- locked_out  out  1  high throughout LOCKOUT.
- led  out  NKEYS  one-hot, active-high copy of the last accepted key; all-ones in ERROR/LOCKOUT.
- digit_cnt  out  $clog2(SEQ_LEN+1)  digits entered in the current attempt.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures.
- state  out  3  IDLE=0, ENTRY=1, CHECK=2, ERROR=3, LOCKOUT=4.

## Operation
- Reset (reset low): all outputs 0, led=0, state=IDLE, all internal counters and the entered-digit register cleared.
- Press event: `key` is registered every cycle into key_prev. A press event fires when `key` has exactly one bit low and key_prev is all-ones.
  - If two or more bits are low, no event fires. A new event needs key_prev to be all-ones again.
- IDLE: a press event stores digit 0, sets digit_cnt=1, updates led, clears the entry timer and moves to ENTRY. match is 0.
- ENTRY:
  - Each press event stores its digit at index digit_cnt, increments digit_cnt, updates led and clears the entry timer.
  - When digit_cnt==SEQ_LEN and `key` is all-ones, move to CHECK.
  - Extra presses after the last digit are ignored.
  - The entry timer increments on every cycle with no press event. When it reaches ENTRY_TIMEOUT, the attempt is a failure (same path as a mismatch, below).
- CHECK (one cycle): compare the entered digits with `code` as sampled in this cycle.
  - Match: toggle unlocked, pulse match, clear fail_cnt, clear digit_cnt, go to IDLE.
  - Mismatch: go to the failure path.
- Failure path: fail_cnt+1. If the new value equals MAX_FAILS, go to LOCKOUT; otherwise go to ERROR. digit_cnt is cleared and the hold timer starts at 0.
- ERROR: error=1. Keys are ignored. After ERROR_HOLD cycles, go to IDLE.
- LOCKOUT: locked_out=1. Keys are ignored. After LOCKOUT_CYCLES cycles, clear fail_cnt and go to IDLE.
- enable low (synchronous): state goes to IDLE, digit_cnt and timers are cleared, error and locked_out are cleared. unlocked, fail_cnt and led are kept.
  - enable low during LOCKOUT still aborts the lockout, but fail_cnt is kept at MAX_FAILS-1 so that the next failure relocks.
- Timers saturate and never wrap. digit_cnt never exceeds SEQ_LEN.

## Timing
- A press event is sampled at edge n. At edge n+1, digit_cnt and led are updated and `state` is ENTRY.
- Release after the final digit at edge n: CHECK is active in cycle n+1; match, unlocked and fail_cnt are updated at edge n+2.
- error/locked_out assert in the cycle after CHECK (or after the timeout edge) and stay high for exactly ERROR_HOLD/LOCKOUT_CYCLES cycles.
- A press and a timeout in the same cycle: the press wins.
- A change on `code` mid-entry has no effect until CHECK.
- reset low at any time forces the reset values immediately, without waiting for a clock edge.

## Test plan
Parameters: NKEYS=4, SEQ_LEN=4, ENTRY_TIMEOUT=20, ERROR_HOLD=10, MAX_FAILS=3, LOCKOUT_CYCLES=30, code=8'h72 (digits 2,0,3,1).
- Correct code: press keys 2,0,3,1, each released between presses → one-cycle match pulse two cycles after the final release; unlocked 0→1; fail_cnt=0. Repeat the sequence → unlocked 1→0.
- Wrong code 2,0,3,0 → error high for exactly 10 cycles, fail_cnt=1, unlocked unchanged, then state=IDLE.
- Three consecutive wrong codes → third attempt enters LOCKOUT; locked_out high for 30 cycles; presses during lockout leave digit_cnt=0; fail_cnt=0 afterwards.
- Press key 2, then idle 20 cycles → timeout failure, ERROR entered, fail_cnt=1.
- Keys 0 and 1 pressed together, then key 0 alone without full release in between → no digit stored. Key held for 50 cycles → counted once.
- Assert reset low mid-entry (digit_cnt=2) and again in LOCKOUT → all outputs 0 immediately. Drop enable mid-entry → IDLE, unlocked preserved.
